decoder_onehot_seq: RTL
=======================

# decoder_onehot_seq

Parametrised SEL_W-to-2^SEL_W one-hot decoder with registered outputs and three operating modes: level decode, single-pulse strobe, and rotating ring sequencer. It sits between the control unit and one-hot consumers: register-file write strobes, bank selects, and multi-phase enables. It supersedes the combinational 3-to-8 decoder wherever a glitch-free, clocked, or self-stepping select is required.

## Interface
- SEL_W, 3, select width; N = 2^SEL_W output lines (derived localparam, SEL_W range 1..6)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- sel  input  SEL_W  index to decode or load
- En  input  1  global enable; low forces y to zero
- mode  input  2  00 DECODE, 01 PULSE, 10 RING, 11 reserved
- load  input  1  RING: load onehot(sel)
- step  input  1  RING: rotate active bit up by one
- y  output  N  registered one-hot (or all-zero) select
- idx  output  SEL_W  binary index of the currently or last active bit
- valid  output  1  high when y is nonzero (registered, equals |y)

## Operation
- Reset (rst_n low, asynchronous): y=0, idx=0, valid=0, En_q=0, mode_q=00, pulse FSM in ARMED.
- Priority every cycle: reset > mode change > En low > mode behaviour.
- Mode change (mode != mode_q): y<=0 for that cycle, idx held, pulse FSM to ARMED; new mode takes effect on the next cycle. mode_q <= mode every cycle.
- En low: y<=0, valid<=0, idx held, pulse FSM to ARMED.
- DECODE (00): y<=onehot(sel), idx<=sel every cycle while En high.
- PULSE (01), FSM states ARMED/FIRED:
  - ARMED and En high and En_q low: y<=onehot(sel), idx<=sel, go FIRED.
  - FIRED: y<=0; stays FIRED while En high; En low returns to ARMED.
  - Exactly one one-cycle pulse per En rising edge; sel changes while FIRED are ignored.
- RING (10):
  - load high: y<=onehot(sel), idx<=sel (load wins over step).
  - step high, load low, y nonzero: y<=rotate-left(y), idx<=idx+1 mod N (N-1 wraps to 0).
  - step with y zero: no effect (ring stays empty until load).
  - neither: hold y and idx.
- Reserved (11): y<=0, idx held.
- y is never multi-hot; idx is always the position of the set bit when valid=1.

## Timing
- All outputs registered; latency sel/En/load/step -> y is 1 clk.
- No combinational path from inputs to outputs.
- PULSE: pulse appears on the clk edge following the first cycle En is sampled high after being sampled low; width exactly 1 clk.
- RING: one rotation per clk while step held high; back-to-back steps allowed.
- Asynchronous reset assertion clears outputs immediately; deassertion takes effect at the next clk edge; reset mid-ring or mid-pulse discards state.

## Test plan
- Reset: assert rst_n=0 mid-operation with y=8'h20 -> y=0, idx=0, valid=0 without waiting for clk.
- DECODE sweep (SEL_W=3): En=1, sel 0..7 -> y 8'h01..8'h80 one cycle later; En=0 -> y=0, idx held at 7.
- PULSE: mode=01, sel=5, hold En high 4 cycles -> y=8'h20 for exactly 1 cycle, then 0; drop En, re-raise with sel=2 -> single y=8'h04 pulse.
- RING wrap: mode=10, load with sel=6, then step 3 cycles -> y 8'h40, 8'h80, 8'h01, 8'h02; idx 6,7,0,1; load+step same cycle with sel=3 -> y=8'h08.
- Mode change: RING holding y=8'h10, switch to DECODE with sel=1 -> one cycle y=0, then y=8'h02; mode=11 -> y=0.
- Width parameter: SEL_W=4, DECODE sel=15 -> y=16'h8000; RING step from idx 15 -> y=16'h0001, idx=0.

Source files
------------

// File: rtl/decoder_onehot_seq_if.sv
// rtl/decoder_onehot_seq_if.sv - select/control inputs and one-hot outputs of decoder_onehot_seq
interface decoder_onehot_seq_if #(
  parameter int SEL_W = 3
) ();
  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0] sel;
  logic             En;
  logic [1:0]       mode;
  logic             load;
  logic             step;
  logic [N-1:0]     y;
  logic [SEL_W-1:0] idx;
  logic             valid;

  modport master (
    output sel, En, mode, load, step,
    input  y, idx, valid
  );

  modport slave (
    input  sel, En, mode, load, step,
    output y, idx, valid
  );
endinterface

// File: rtl/decoder_onehot_seq.sv
// rtl/decoder_onehot_seq.sv - registered one-hot decoder with level, pulse and ring modes
module decoder_onehot_seq #(
  parameter int SEL_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  decoder_onehot_seq_if.slave  bus
);
  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    M_DECODE = 2'b00,
    M_PULSE  = 2'b01,
    M_RING   = 2'b10,
    M_RSVD   = 2'b11
  } mode_t;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } pulse_t;

  pulse_t      state;
  logic        en_q;
  logic [1:0]  mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y     <= '0;
      bus.idx   <= '0;
      bus.valid <= 1'b0;
      en_q      <= 1'b0;
      mode_q    <= M_DECODE;
      state     <= ARMED;
    end else begin
      en_q   <= bus.En;
      mode_q <= bus.mode;
      // A mode switch blanks y for one cycle so no stale select leaks into the new mode.
      if (bus.mode != mode_q || !bus.En) begin
        bus.y     <= '0;
        bus.valid <= 1'b0;
        state     <= ARMED;
      end else begin
        case (mode_t'(bus.mode))
          M_DECODE: begin
            bus.y     <= ONE << bus.sel;
            bus.idx   <= bus.sel;
            bus.valid <= 1'b1;
            state     <= ARMED;
          end
          M_PULSE: begin
            if (state == ARMED && !en_q) begin
              bus.y     <= ONE << bus.sel;
              bus.idx   <= bus.sel;
              bus.valid <= 1'b1;
              state     <= FIRED;
            end else begin
              bus.y     <= '0;
              bus.valid <= 1'b0;
            end
          end
          M_RING: begin
            state <= ARMED;
            if (bus.load) begin
              bus.y     <= ONE << bus.sel;
              bus.idx   <= bus.sel;
              bus.valid <= 1'b1;
            end else if (bus.step && bus.valid) begin
              // An empty ring stays empty; only a load can seed it.
              bus.y   <= {bus.y[N-2:0], bus.y[N-1]};
              bus.idx <= bus.idx + SEL_W'(1);
            end
          end
          default: begin
            bus.y     <= '0;
            bus.valid <= 1'b0;
            state     <= ARMED;
          end
        endcase
      end
    end
  end
endmodule
